// File: rtl/corr_lock_detector.sv
// Lock/loss detector driven by the per-cycle mismatch flag of a cross-correlation stage.
// Latency: every output is registered and changes one clk edge after the sample that causes it.
// No backpressure: one z_i sample is consumed every enabled cycle.
// Optional macro CORR_LOCK_STATS_EN adds the saturating loss_cnt_o event counter port.
module corr_lock_detector #(
  parameter int LOCK_CNT = 8,   // consecutive clean samples needed to lock (1..255)
  parameter int LOSS_CNT = 4,   // mismatches within one window that drop lock (1..WIN_LEN)
  parameter int WIN_LEN  = 16   // observation window length while locked (2..255)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic       z_i,
  output logic       locked_o,
  output logic       lock_pulse_o,
  output logic       loss_pulse_o,
  output logic [1:0] state_o
`ifdef CORR_LOCK_STATS_EN
  ,
  output logic [7:0] loss_cnt_o
`endif
);

  // Counter widths are sized to hold the parameter value itself.
  localparam int RW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WIN_LEN + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);

  localparam logic [RW-1:0] RUN_LAST = RW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(WIN_LEN - 1);
  localparam logic [MW-1:0] MIS_LAST = MW'(LOSS_CNT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACQ    = 2'b01,
    LOCKED = 2'b10,
    LOST   = 2'b11
  } state_t;

  state_t        state;
  logic [RW-1:0] run_cnt;
  logic [WW-1:0] win_cnt;
  logic [MW-1:0] mis_cnt;

  // Terminal-condition decodes; the counters never pass these values.
  logic run_done;
  logic win_last;
  logic loss_hit;

  assign run_done = (run_cnt == RUN_LAST);
  assign win_last = (win_cnt == WIN_LAST);
  // The current sample counts toward the threshold.
  assign loss_hit = z_i && (mis_cnt == MIS_LAST);

  assign state_o = state;

  // Main FSM: state, counters and all registered flag outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      run_cnt      <= '0;
      win_cnt      <= '0;
      mis_cnt      <= '0;
      locked_o     <= 1'b0;
      lock_pulse_o <= 1'b0;
      loss_pulse_o <= 1'b0;
    end else begin
      lock_pulse_o <= 1'b0;
      loss_pulse_o <= 1'b0;
      if (!en_i) begin
        // Disable wins over everything and never produces a pulse.
        state    <= IDLE;
        run_cnt  <= '0;
        win_cnt  <= '0;
        mis_cnt  <= '0;
        locked_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state   <= ACQ;
            run_cnt <= '0;
            win_cnt <= '0;
            mis_cnt <= '0;
          end

          ACQ: begin
            if (z_i) begin
              run_cnt <= '0;
            end else if (run_done) begin
              state        <= LOCKED;
              locked_o     <= 1'b1;
              lock_pulse_o <= 1'b1;
              run_cnt      <= '0;
              win_cnt      <= '0;
              mis_cnt      <= '0;
            end else begin
              run_cnt <= run_cnt + RW'(1);
            end
          end

          LOCKED: begin
            if (loss_hit) begin
              // Loss beats the end-of-window clear.
              state        <= LOST;
              locked_o     <= 1'b0;
              loss_pulse_o <= 1'b1;
              win_cnt      <= '0;
              mis_cnt      <= '0;
            end else if (win_last) begin
              win_cnt <= '0;
              mis_cnt <= '0;
            end else begin
              win_cnt <= win_cnt + WW'(1);
              mis_cnt <= mis_cnt + MW'(z_i);
            end
          end

          LOST: begin
            // Single-cycle marker state; reacquire from scratch.
            state   <= ACQ;
            run_cnt <= '0;
            win_cnt <= '0;
            mis_cnt <= '0;
          end

          default: begin
            state    <= IDLE;
            locked_o <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef CORR_LOCK_STATS_EN
  logic loss_evt;
  assign loss_evt = en_i && (state == LOCKED) && loss_hit;

  // Saturating count of loss events, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      loss_cnt_o <= 8'd0;
    end else if (loss_evt && (loss_cnt_o != 8'hFF)) begin
      loss_cnt_o <= loss_cnt_o + 8'd1;
    end
  end
`endif

endmodule
